// File: rtl/conv_pkg.sv
// Shared definitions for convolution layer writers: lane geometry, writer
// state encoding and the 32-bit to 8-bit requantizer (shift, ReLU, saturate).
package conv_pkg;

  localparam int NUM_PE = 4;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } writer_state_e;

  // Arithmetic shift, then clamp into the unsigned 8-bit activation range.
  function automatic logic [7:0] requantize(input logic signed [ACC_W-1:0] acc,
                                            input logic [4:0]              shift);
    logic signed [ACC_W-1:0] s;
    logic [7:0]              q;
    s = acc >>> shift;
    if (s < 0) begin
      q = 8'd0;
    end else if (s > 255) begin
      q = 8'hFF;
    end else begin
      q = s[7:0];
    end
    return q;
  endfunction

endpackage

// File: rtl/conv_ofm_fifo.sv
// Synchronous word FIFO between lane packing and the OFM write port.
// Push is refused when full, even if a pop happens in the same cycle.
module conv_ofm_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/conv1x1_ofm_writer.sv
// OFM writer for 1x1 convolution: captures per-lane PE results, requantizes
// them, packs NUM_PE bytes per word and streams words to the OFM buffer.
module conv1x1_ofm_writer
  import conv_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_start,
  input  logic [7:0]              cfg_num_filter,
  input  logic [15:0]             cfg_num_pixel,
  input  logic [4:0]              cfg_shift,
  input  logic [NUM_PE-1:0]       pe_finish,
  input  logic [NUM_PE*ACC_W-1:0] pe_data,
  output logic                    busy,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*NUM_PE-1:0]     wr_data,
  output logic                    done,
  output logic                    ovf_err
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W = 8 * NUM_PE;

  writer_state_e state_q, state_d;

  logic [23:0]             total_q, total_d;
  logic [23:0]             words_q, words_d;
  logic [4:0]              shift_q, shift_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [NUM_PE-1:0]       lane_full_q, lane_full_d;
  logic [NUM_PE-1:0][7:0]  lane_byte_q, lane_byte_d;
  logic                    ovf_q, ovf_d;

  logic [23:0]             start_total;
  logic                    start_accept, capture_en;
  logic                    push, pop, last_word;
  logic                    fifo_full, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [WORD_W-1:0]       fifo_head;

  assign start_total = 24'(cfg_num_pixel) * 24'(cfg_num_filter >> 2);
  assign push        = (state_q == ST_RUN) && (&lane_full_q) && !fifo_full;
  assign last_word   = push && ((words_q + 24'd1) == total_q);
  assign pop         = wr_valid && wr_ready;

  conv_ofm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (lane_byte_q),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // DRAIN looks ahead at the final pop so done lands right after the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_start) state_d = (start_total == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_word) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty || (fifo_count == CNT_W'(1) && pop)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_accept = 1'b0;
    capture_en   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_IDLE:  start_accept = cfg_start;
      ST_RUN: begin
        busy       = 1'b1;
        capture_en = !last_word;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Lanes cleared by a push in this cycle may capture a new strobe at once.
  always_comb begin
    total_d     = total_q;
    shift_d     = shift_q;
    words_d     = words_q;
    addr_d      = addr_q;
    lane_full_d = lane_full_q;
    lane_byte_d = lane_byte_q;
    ovf_d       = ovf_q;
    if (start_accept) begin
      total_d     = start_total;
      shift_d     = cfg_shift;
      words_d     = '0;
      addr_d      = '0;
      lane_full_d = '0;
      ovf_d       = 1'b0;
    end else begin
      if (push) begin
        words_d     = words_q + 24'd1;
        lane_full_d = '0;
      end
      if (pop) addr_d = addr_q + ADDR_W'(4);
      for (int i = 0; i < NUM_PE; i++) begin
        if (capture_en && pe_finish[i]) begin
          if (lane_full_d[i]) begin
            ovf_d = 1'b1;
          end else begin
            lane_full_d[i] = 1'b1;
            lane_byte_d[i] = requantize(pe_data[i*ACC_W +: ACC_W], shift_q);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_q     <= '0;
      shift_q     <= '0;
      words_q     <= '0;
      addr_q      <= '0;
      lane_full_q <= '0;
      lane_byte_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      total_q     <= total_d;
      shift_q     <= shift_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      lane_full_q <= lane_full_d;
      lane_byte_q <= lane_byte_d;
      ovf_q       <= ovf_d;
    end
  end

  assign wr_valid = !fifo_empty;
  assign wr_data  = fifo_empty ? '0 : fifo_head;
  assign wr_addr  = addr_q;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_conv1x1_ofm_writer.sv
// Scoreboard bench for conv1x1_ofm_writer: the driver queues expected writes
// from a reference requantizer, a monitor pops and compares on each handshake.
module tb_conv1x1_ofm_writer;

  localparam int FIFO_DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_start;
  logic [7:0]   cfg_num_filter;
  logic [15:0]  cfg_num_pixel;
  logic [4:0]   cfg_shift;
  logic [3:0]   pe_finish;
  logic [127:0] pe_data;
  logic         busy, wr_valid, wr_ready, done, ovf_err;
  logic [31:0]  wr_addr, wr_data;

  always #5 clk = ~clk;

  conv1x1_ofm_writer #(.ADDR_W(32), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_num_filter (cfg_num_filter),
    .cfg_num_pixel  (cfg_num_pixel),
    .cfg_shift      (cfg_shift),
    .pe_finish      (pe_finish),
    .pe_data        (pe_data),
    .busy           (busy),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .done           (done),
    .ovf_err        (ovf_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          cyc = 0, ready_mode = 1;
  int          sent = 0, written = 0;
  int          done_cnt = 0, done_cyc = -1, last_hs_cyc = -1, layer_done_base = 0;
  int unsigned cur_shift = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference requantizer: floor division by 2^sh, then clamp to 0..255.
  function automatic logic [7:0] ref_byte(input logic [31:0] acc, input int unsigned sh);
    longint a, d, s;
    a = longint'($signed(acc));
    d = longint'(1) << sh;
    if (a >= 0) s = a / d;
    else        s = -((-a + d - 1) / d);
    if (s < 0)   return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  function automatic logic [31:0] ref_word(input logic [3:0][31:0] acc, input int unsigned sh);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_byte(acc[i], sh);
    return w;
  endfunction

  function automatic logic [31:0] rand_acc(input int unsigned sh);
    longint v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    v = longint'($urandom_range(0, 700)) - 200;
    v = v * (longint'(1) << sh) + longint'($urandom_range(0, (1 << sh) - 1));
    return 32'(v);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       wr_ready = 1'b0;
        1:       wr_ready = 1'b1;
        default: wr_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: handshake scoreboard, stall stability and done bookkeeping.
  initial begin
    exp_t        e;
    bit          prev_stall;
    logic [31:0] prev_addr, prev_data;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (prev_stall) begin
          check("stall_valid", wr_valid, 1);
          check("stall_addr", wr_addr, prev_addr);
          check("stall_data", wr_data, prev_data);
        end
        if (wr_valid && wr_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr=%0h data=%0h with empty scoreboard", wr_addr, wr_data);
          end else begin
            e = sb.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
          end
          written++;
          last_hs_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = wr_valid && !wr_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int pix, input int filt, input int sh);
    cfg_num_pixel   = 16'(pix);
    cfg_num_filter  = 8'(filt);
    cfg_shift       = 5'(sh);
    cfg_start       = 1'b1;
    sent            = 0;
    written         = 0;
    cur_shift       = sh;
    layer_done_base = done_cnt;
    tick();
    cfg_start      = 1'b0;
    cfg_num_pixel  = 16'($urandom);
    cfg_num_filter = 8'($urandom);
    cfg_shift      = 5'($urandom);
  endtask

  // mode 0: all lanes together, 1: one lane per cycle from lane 3 down, 2: random.
  task automatic send_word(input logic [3:0][31:0] acc, input logic [31:0] exp_data,
                           input int mode, input bit throttle);
    logic [3:0] pending, fire;
    int         budget;
    exp_t       e;
    if (throttle) begin
      budget = 0;
      while ((sent - written) >= FIFO_DEPTH && budget < 500) begin
        tick();
        budget++;
      end
      if (budget >= 500) check("throttle_timeout", written, sent - FIFO_DEPTH + 1);
    end
    e.addr = 32'(sent * 4);
    e.data = exp_data;
    sb.push_back(e);
    sent++;
    pending = 4'hF;
    while (pending != 4'h0) begin
      case (mode)
        0: fire = pending;
        1: begin
          fire = 4'h0;
          for (int i = 0; i < 4; i++) if (pending[i]) fire = 4'(1) << i;
        end
        default: fire = pending & 4'($urandom);
      endcase
      for (int i = 0; i < 4; i++) pe_data[32*i +: 32] = fire[i] ? acc[i] : $urandom;
      pe_finish = fire;
      pending   = pending & ~fire;
      tick();
    end
    pe_finish = 4'h0;
  endtask

  task automatic send_random_word(input int mode, input bit throttle);
    logic [3:0][31:0] acc;
    for (int i = 0; i < 4; i++) acc[i] = rand_acc(cur_shift);
    send_word(acc, ref_word(acc, cur_shift), mode, throttle);
  endtask

  task automatic finish_layer(input string tag);
    int budget;
    budget = 0;
    while (done_cnt == layer_done_base && budget < 1000) begin
      tick();
      budget++;
    end
    check({tag, "_done_seen"}, done_cnt - layer_done_base, 1);
    check({tag, "_done_timing"}, done_cyc, last_hs_cyc + 1);
    check({tag, "_write_count"}, written, sent);
    check({tag, "_sb_empty"}, sb.size(), 0);
    tick();
    tick();
    check({tag, "_done_once"}, done_cnt - layer_done_base, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovf_err"}, ovf_err, 0);
  endtask

  initial begin
    logic [3:0][31:0] acc;
    int               budget;

    reset_n        = 1'b0;
    cfg_start      = 1'b0;
    cfg_num_filter = '0;
    cfg_num_pixel  = '0;
    cfg_shift      = '0;
    pe_finish      = '0;
    pe_data        = '0;
    repeat (2) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Single word, lanes together: bytes 255, 255, 0, 5 from lane 3 down.
    ready_mode = 1;
    start_layer(1, 4, 0);
    check("t1_busy", busy, 1);
    acc = {32'd255, 32'd300, 32'hFFFF_FFFD, 32'd5};
    send_word(acc, 32'hFFFF_0005, 0, 1);
    finish_layer("t1");

    // 2 pixels x 8 filters, reverse stagger, with a stray start during RUN.
    start_layer(2, 8, 3);
    for (int w = 0; w < 4; w++) begin
      send_random_word(1, 1);
      if (w == 0) begin
        cfg_num_pixel = 16'd0;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
      end
    end
    finish_layer("t2");

    // Shift 4 saturation, mid-range and negative cases.
    start_layer(1, 4, 4);
    acc = {$urandom, 32'hFFFF_FFF0, 32'h0000_07F0, 32'h0000_0FF0};
    send_word(acc, {ref_byte(acc[3], 4), 8'd0, 8'd127, 8'd255}, 2, 1);
    finish_layer("t3");

    // Stalled writer: 4 words fill the FIFO, the 5th waits in lanes, then overrun.
    ready_mode = 0;
    start_layer(2, 12, 0);
    check("t4_ovf_clear", ovf_err, 0);
    for (int w = 0; w < 5; w++) send_random_word(2, 0);
    tick();
    tick();
    check("t4_ovf_before", ovf_err, 0);
    check("t4_valid_stalled", wr_valid, 1);
    check("t4_addr_stalled", wr_addr, 0);
    pe_data[31:0] = 32'd77;
    pe_finish     = 4'b0001;
    tick();
    pe_finish = 4'h0;
    check("t4_ovf_set", ovf_err, 1);
    repeat (3) tick();
    ready_mode = 1;
    send_random_word(0, 1);
    finish_layer("t4");
    check("t4_ovf_sticky", ovf_err, 1);

    // Zero-size layers: done right after the start, no writes.
    start_layer(0, 8, 0);
    check("t5_ovf_cleared", ovf_err, 0);
    check("t5_done", done, 1);
    check("t5_no_valid", wr_valid, 0);
    check("t5_busy", busy, 0);
    tick();
    check("t5_done_pulse", done, 0);
    start_layer(5, 3, 0);
    check("t5b_done", done, 1);
    check("t5b_no_valid", wr_valid, 0);
    tick();

    // Reset mid-layer after two writes, then a fresh layer from address 0.
    start_layer(3, 4, 0);
    send_random_word(0, 1);
    send_random_word(2, 1);
    budget = 0;
    while (written < 2 && budget < 200) begin
      tick();
      budget++;
    end
    check("t6_two_writes", written, 2);
    pe_finish = 4'b0011;
    tick();
    pe_finish = 4'h0;
    reset_n   = 1'b0;
    #1;
    check_all_zero("t6_reset");
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    ready_mode = 2;
    start_layer(2, 8, $urandom_range(0, 12));
    for (int w = 0; w < 4; w++) send_random_word(2, 1);
    finish_layer("t6");

    // Random layers with random backpressure.
    for (int l = 0; l < 4; l++) begin
      int pix, filt;
      pix  = $urandom_range(1, 3);
      filt = $urandom_range(4, 15);
      start_layer(pix, filt, $urandom_range(0, 20));
      for (int w = 0; w < pix * (filt / 4); w++) send_random_word($urandom_range(0, 2), 1);
      finish_layer("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
